// File: rtl/cordic_vec.sv
// Iterative vectoring-mode CORDIC: converts a Cartesian point (x, y) to magnitude and
// four-quadrant angle atan2(y, x), one vector at a time over a valid/ready handshake.
module cordic_vec #(
  parameter int D_WIDTH = 7,
  parameter int ITER    = D_WIDTH,
  parameter int G       = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [D_WIDTH-1:0] x_in,
  input  logic signed [D_WIDTH-1:0] y_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic        [D_WIDTH:0]   mag_out,
  output logic signed [D_WIDTH+1:0] z_out
);

  localparam int W  = D_WIDTH + G + 2;
  localparam int CW = $clog2(ITER);
  localparam int PW = W + 18;
  localparam logic signed [W-1:0]  Z_PI   = W'(2 ** (D_WIDTH + G));
  localparam logic signed [PW-1:0] MAGMAX = PW'((2 ** (D_WIDTH + 1)) - 1);

  typedef enum logic [1:0] {IDLE, ROT, SCALE, DONE} state_t;

  state_t                state;
  logic signed [W-1:0]   x_r, y_r, z_r;
  logic        [CW-1:0]  iter_r;
  logic                  zero_flag;

  // atan(2^-i) in units of PI/2^(D_WIDTH+G); table holds atan(2^-i)/PI scaled by 2^32.
  function automatic logic signed [W-1:0] atan_lsb(input int idx);
    logic [31:0] t;
    logic [63:0] r;
    case (idx)
      0:       t = 32'd1073741824;
      1:       t = 32'd633866812;
      2:       t = 32'd334917814;
      3:       t = 32'd170009512;
      4:       t = 32'd85334662;
      5:       t = 32'd42708930;
      6:       t = 32'd21359676;
      7:       t = 32'd10680490;
      8:       t = 32'd5340326;
      9:       t = 32'd2670174;
      10:      t = 32'd1335088;
      11:      t = 32'd667544;
      12:      t = 32'd333772;
      13:      t = 32'd166886;
      14:      t = 32'd83444;
      15:      t = 32'd41722;
      default: t = 32'd0;
    endcase
    r = (64'(t) + (64'd1 << (31 - (D_WIDTH + G)))) >> (32 - (D_WIDTH + G));
    return $signed(W'(r));
  endfunction

  // Drop the G guard bits with round-half-up.
  function automatic logic signed [D_WIDTH+1:0] round_z(input logic signed [W-1:0] v);
    logic signed [W:0] t;
    t = (W+1)'(v) + (W+1)'(2 ** (G - 1));
    return (D_WIDTH+2)'(t >>> G);
  endfunction

  // Remove the CORDIC gain (1/K ~ 39797/2^16), drop guard bits, clamp to the output range.
  function automatic logic [D_WIDTH:0] scale_mag(input logic signed [W-1:0] v);
    logic signed [PW-1:0] p;
    p = PW'(v) * $signed(PW'(39797));
    p = (p + PW'(32768)) >>> 16;
    p = (p + PW'(2 ** (G - 1))) >>> G;
    if (p < 0)
      return '0;
    else if (p > MAGMAX)
      return '1;
    else
      return (D_WIDTH+1)'(p);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      mag_out   <= '0;
      z_out     <= '0;
      x_r       <= '0;
      y_r       <= '0;
      z_r       <= '0;
      iter_r    <= '0;
      zero_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Left half-plane points are reflected through the origin and start at +/-PI.
            if (!x_in[D_WIDTH-1]) begin
              x_r <= W'(x_in) <<< G;
              y_r <= W'(y_in) <<< G;
              z_r <= '0;
            end else begin
              x_r <= -(W'(x_in) <<< G);
              y_r <= -(W'(y_in) <<< G);
              z_r <= y_in[D_WIDTH-1] ? -Z_PI : Z_PI;
            end
            zero_flag <= (x_in == '0) && (y_in == '0);
            iter_r    <= '0;
            in_ready  <= 1'b0;
            state     <= ROT;
          end
        end
        ROT: begin
          if (!y_r[W-1]) begin
            x_r <= x_r + (y_r >>> iter_r);
            y_r <= y_r - (x_r >>> iter_r);
            z_r <= z_r + atan_lsb(int'(iter_r));
          end else begin
            x_r <= x_r - (y_r >>> iter_r);
            y_r <= y_r + (x_r >>> iter_r);
            z_r <= z_r - atan_lsb(int'(iter_r));
          end
          iter_r <= iter_r + CW'(1);
          if (iter_r == CW'(ITER - 1))
            state <= SCALE;
        end
        SCALE: begin
          mag_out   <= zero_flag ? '0 : scale_mag(x_r);
          z_out     <= zero_flag ? '0 : round_z(z_r);
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_vec.sv
// Bench for cordic_vec: table vectors, handshake/reset sequences, and random points
// compared against real-valued atan2/sqrt.
module tb_cordic_vec;

  localparam int  DW = 7;
  localparam real PI = 3.14159265358979;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] x_in;
  logic signed [DW-1:0] y_in;
  logic                 out_valid;
  logic                 out_ready;
  logic        [DW:0]   mag_out;
  logic signed [DW+1:0] z_out;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cordic_vec #(.D_WIDTH(DW), .ITER(DW), .G(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x_in     (x_in),
    .y_in     (y_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .mag_out  (mag_out),
    .z_out    (z_out)
  );

  typedef struct {
    int  x;
    int  y;
    real z;
    real m;
    real tol;
  } vec_t;

  task automatic chk(input string name, input real act, input real exp, input real tol);
    n_vec++;
    if ((act - exp > tol) || (exp - act > tol)) begin
      n_bad++;
      $display("FAIL %s: got %0.3f, want %0.3f (tol %0.1f)", name, act, exp, tol);
    end
  endtask

  // Angles are compared modulo a full turn so +PI and -PI count as the same direction.
  task automatic chk_ang(input string name, input real act, input real exp, input real tol);
    real d;
    d = act - exp;
    if (d > 128.0) d = d - 256.0;
    if (d < -128.0) d = d + 256.0;
    chk(name, exp + d, exp, tol);
  endtask

  function automatic real ref_z(input int x, input int y);
    return $atan2(real'(y), real'(x)) * 128.0 / PI;
  endfunction

  function automatic real ref_m(input int x, input int y);
    return $sqrt(real'(x * x + y * y));
  endfunction

  // Called at a negedge with the block idle; returns at the negedge after the output handshake.
  task automatic send(input int x, input int y, output int lat, output int m, output int z,
                      output bit to);
    chk("in_ready_idle", in_ready, 1, 0);
    x_in     = DW'(x);
    y_in     = DW'(y);
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    to = !out_valid;
    m  = int'(mag_out);
    z  = int'(z_out);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    vec_t tbl[6];
    int   lat, m, z, m0, z0, cnt;
    bit   to, seen, stable;

    tbl[0] = '{63, 0, 0.0, 63.0, 2.0};
    tbl[1] = '{45, 45, 32.0, 64.0, 2.0};
    tbl[2] = '{0, -64, -64.0, 64.0, 2.0};
    tbl[3] = '{-64, 0, 128.0, 64.0, 2.0};
    tbl[4] = '{-64, -1, -127.0, 64.0, 2.0};
    tbl[5] = '{0, 0, 0.0, 0.0, 0.0};

    rst_n     = 1'b0;
    in_valid  = 1'b1;
    x_in      = 7'sd40;
    y_in      = 7'sd20;
    out_ready = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0, 0);
      chk("rst_mag", mag_out, 0, 0);
      chk("rst_z", z_out, 0, 0);
    end
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1, 0);
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("no_accept_in_rst", seen, 0, 0);

    for (int i = 0; i < 6; i++) begin
      send(tbl[i].x, tbl[i].y, lat, m, z, to);
      chk("tbl_timeout", to, 0, 0);
      chk("tbl_latency", lat, 9, 0);
      chk("tbl_mag", m, tbl[i].m, tbl[i].tol);
      chk_ang("tbl_z", z, tbl[i].z, tbl[i].tol);
    end

    // Backpressure: result held while in_valid wiggles.
    x_in = 7'sd30;
    y_in = 7'sd40;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 40) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
    end
    chk("bp_timeout", out_valid, 1, 0);
    m0 = int'(mag_out);
    z0 = int'(z_out);
    chk("bp_mag", m0, 50.0, 2.0);
    chk_ang("bp_z", z0, ref_z(30, 40), 2.0);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      x_in = DW'($urandom_range(0, 127));
      y_in = DW'($urandom_range(0, 127));
      @(posedge clk);
      @(negedge clk);
      if (!out_valid || in_ready || int'(mag_out) != m0 || int'(z_out) != z0) stable = 1'b0;
    end
    chk("bp_stable", stable, 1, 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_hs_out_valid", out_valid, 0, 0);
    chk("bp_hs_in_ready", in_ready, 1, 0);
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("bp_no_new_accept", seen, 0, 0);

    // Reset pulse in the middle of the rotations.
    x_in = 7'sd50;
    y_in = 7'sd20;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_in_ready", in_ready, 1, 0);
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("midrst_no_result", seen, 0, 0);
    send(63, 0, lat, m, z, to);
    chk("midrst_timeout", to, 0, 0);
    chk("midrst_latency", lat, 9, 0);
    chk("midrst_mag", m, 63.0, 2.0);
    chk_ang("midrst_z", z, 0.0, 2.0);

    // Points around the upper-right quarter circle, as a rotator would produce them.
    for (int k = 0; k < 64; k++) begin
      int cx, cy;
      cx = int'(63.0 * $cos(real'(k) * PI / 128.0));
      cy = int'(63.0 * $sin(real'(k) * PI / 128.0));
      send(cx, cy, lat, m, z, to);
      chk("circle_timeout", to, 0, 0);
      chk_ang("circle_z", z, ref_z(cx, cy), 2.0);
      chk_ang("circle_k", z, real'(k), 2.5);
    end

    // Random points over the whole input square.
    for (int n = 0; n < 1500; n++) begin
      int rx, ry;
      rx = int'($urandom_range(0, 127)) - 64;
      ry = int'($urandom_range(0, 127)) - 64;
      send(rx, ry, lat, m, z, to);
      chk("rand_timeout", to, 0, 0);
      if (rx == 0 && ry == 0) begin
        chk("rand_zero_mag", m, 0, 0);
        chk("rand_zero_z", z, 0, 0);
      end else begin
        chk("rand_mag", m, ref_m(rx, ry), 2.0);
        chk_ang("rand_z", z, ref_z(rx, ry), 2.0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
